// File: rtl/lint_pkg.sv
// rtl/lint_pkg.sv - shared state type and widths for the event queue
package lint_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } q_state_t;

    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/lint_sat_counter.sv
// rtl/lint_sat_counter.sv - saturating up-counter with async active-high reset
module lint_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lint_event_queue.sv
// rtl/lint_event_queue.sv - FWFT event queue with flush and drop counter
module lint_event_queue
    import lint_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] out_count,
    output logic [DROP_CNT_W-1:0]      out_drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    q_state_t         state, next_state;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push, pop, drop;

    // Ready and valid depend only on state so neither side sees a comb path.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = mem[rd_ptr];
    assign out_count = count;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    assign drop = in_valid && !in_ready && !flush;

    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (push) next_state = ACTIVE;
            ACTIVE: begin
                if (push && !pop && (count == LAST)) next_state = FULL;
                else if (pop && !push && (count == ONE)) next_state = EMPTY;
            end
            FULL:    if (pop) next_state = ACTIVE;
            default: next_state = EMPTY;
        endcase
        if (flush) next_state = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= next_state;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; out_data simply shows stale contents when empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_data;
    end

    lint_sat_counter #(
        .W(DROP_CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (drop),
        .count(out_drop_cnt)
    );

endmodule

// File: tb/tb_lint_event_queue.sv
// tb/tb_lint_event_queue.sv - table-driven self-checking bench for lint_event_queue
module tb_lint_event_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic [2:0] out_count;
    logic [7:0] out_drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lint_event_queue #(.DEPTH(4), .WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .out_drop_cnt(out_drop_cnt)
    );

    typedef struct {
        logic       fl;
        logic       iv;
        logic [3:0] id;
        logic       ordy;
        logic       e_ov;
        logic       e_ir;
        logic [3:0] e_od;
        logic [2:0] e_cnt;
        logic [7:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [3:0] id,
                                input logic ordy, input logic e_ov, input logic e_ir,
                                input logic [3:0] e_od, input logic [2:0] e_cnt,
                                input logic [7:0] e_drop);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od; v.e_cnt = e_cnt; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [3:0] id, input logic ordy);
        flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 4'h0, 0);

        // three pushes, then drain in order
        vecs.push_back(mk(0, 1, 4'h3, 0, 1, 1, 4'h3, 1, 0));
        vecs.push_back(mk(0, 1, 4'h5, 0, 1, 1, 4'h3, 2, 0));
        vecs.push_back(mk(0, 1, 4'hA, 0, 1, 1, 4'h3, 3, 0));
        vecs.push_back(mk(0, 0, 4'h0, 1, 1, 1, 4'h5, 2, 0));
        vecs.push_back(mk(0, 0, 4'h0, 1, 1, 1, 4'hA, 1, 0));
        vecs.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h0, 0, 0));
        // six offers into a 4-deep queue
        vecs.push_back(mk(0, 1, 4'h1, 0, 1, 1, 4'h1, 1, 0));
        vecs.push_back(mk(0, 1, 4'h2, 0, 1, 1, 4'h1, 2, 0));
        vecs.push_back(mk(0, 1, 4'h3, 0, 1, 1, 4'h1, 3, 0));
        vecs.push_back(mk(0, 1, 4'h4, 0, 1, 0, 4'h1, 4, 0));
        vecs.push_back(mk(0, 1, 4'h5, 0, 1, 0, 4'h1, 4, 1));
        vecs.push_back(mk(0, 1, 4'h6, 0, 1, 0, 4'h1, 4, 2));
        // pop while full with an offer pending: pop only, one more drop
        vecs.push_back(mk(0, 1, 4'h7, 1, 1, 1, 4'h2, 3, 3));
        vecs.push_back(mk(0, 0, 4'h0, 1, 1, 1, 4'h3, 2, 3));
        // steady push+pop at count 2, pointers wrap
        vecs.push_back(mk(0, 1, 4'h8, 1, 1, 1, 4'h4, 2, 3));
        vecs.push_back(mk(0, 1, 4'h9, 1, 1, 1, 4'h8, 2, 3));
        vecs.push_back(mk(0, 1, 4'hA, 1, 1, 1, 4'h9, 2, 3));
        vecs.push_back(mk(0, 1, 4'hB, 1, 1, 1, 4'hA, 2, 3));
        vecs.push_back(mk(0, 1, 4'hC, 1, 1, 1, 4'hB, 2, 3));
        vecs.push_back(mk(0, 1, 4'hD, 1, 1, 1, 4'hC, 2, 3));
        vecs.push_back(mk(0, 1, 4'hE, 1, 1, 1, 4'hD, 2, 3));
        vecs.push_back(mk(0, 1, 4'hF, 1, 1, 1, 4'hE, 2, 3));
        vecs.push_back(mk(0, 1, 4'h0, 1, 1, 1, 4'hF, 2, 3));
        vecs.push_back(mk(0, 1, 4'h1, 1, 1, 1, 4'h0, 2, 3));
        // flush with an offer at count 3, then flush while full
        vecs.push_back(mk(0, 1, 4'h2, 0, 1, 1, 4'h0, 3, 3));
        vecs.push_back(mk(1, 1, 4'h5, 0, 0, 1, 4'h0, 0, 3));
        vecs.push_back(mk(0, 1, 4'h1, 0, 1, 1, 4'h1, 1, 3));
        vecs.push_back(mk(0, 1, 4'h2, 0, 1, 1, 4'h1, 2, 3));
        vecs.push_back(mk(0, 1, 4'h3, 0, 1, 1, 4'h1, 3, 3));
        vecs.push_back(mk(0, 1, 4'h4, 0, 1, 0, 4'h1, 4, 3));
        vecs.push_back(mk(1, 1, 4'h9, 0, 0, 1, 4'h1, 0, 3));
        vecs.push_back(mk(0, 0, 4'h0, 0, 0, 1, 4'h1, 0, 3));

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_count", out_count, 0);
        check("reset_drop", out_drop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
            check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
            check($sformatf("v%0d_count", i), out_count, vecs[i].e_cnt);
            check($sformatf("v%0d_drop", i), out_drop_cnt, vecs[i].e_drop);
            if (vecs[i].e_ov) check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
        end

        // no same-cycle bypass: valid rises only after the edge
        @(negedge clk);
        drive(0, 1, 4'h9, 0);
        #1;
        check("bypass_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_out_valid", out_valid, 1);
        check("latency_out_data", out_data, 4'h9);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 1, 4'(k + 1), 0);
            @(posedge clk);
        end
        #1;
        check("prefill_in_ready", in_ready, 0);
        check("prefill_count", out_count, 4);

        // async reset between edges while full
        @(negedge clk);
        drive(0, 0, 4'h0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_in_ready", in_ready, 1);
        check("async_count", out_count, 0);
        check("async_drop", out_drop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 4'h6, 0);
        @(posedge clk);
        #1;
        check("resume_count", out_count, 1);
        check("resume_out_data", out_data, 4'h6);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 1, 4'h7, 0);
            @(posedge clk);
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            drive(0, 1, 4'h8, 0);
            @(posedge clk);
            #1;
            if (k == 253) check("drop_254", out_drop_cnt, 254);
        end
        check("drop_saturated", out_drop_cnt, 255);
        check("sat_count", out_count, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
